// File: rtl/gcd_req_scheduler_pkg.sv
// gcd_req_scheduler_pkg: shared FSM encoding and default sizes for the GCD scheduler
package gcd_req_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, REDUCE, DONE} state_t;
  localparam int GCD_WIDTH = 8;
  localparam int GCD_NREQ = 2;
endpackage

// File: rtl/gcd_req_scheduler_if.sv
// gcd_req_scheduler_if: requester/response bus; rsp_cycles exists only with GCD_CYCLE_COUNT_EN
interface gcd_req_scheduler_if #(parameter int WIDTH = 8, parameter int NREQ = 2);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*WIDTH-1:0] req_u;
  logic [NREQ*WIDTH-1:0] req_v;
  logic rsp_valid;
  logic rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [WIDTH-1:0] rsp_gcd;
`ifdef GCD_CYCLE_COUNT_EN
  logic [WIDTH-1:0] rsp_cycles;
  modport master (output req_valid, req_u, req_v, rsp_ready,
                  input req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_cycles);
  modport slave (input req_valid, req_u, req_v, rsp_ready,
                 output req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_cycles);
`else
  modport master (output req_valid, req_u, req_v, rsp_ready,
                  input req_ready, rsp_valid, rsp_id, rsp_gcd);
  modport slave (input req_valid, req_u, req_v, rsp_ready,
                 output req_ready, rsp_valid, rsp_id, rsp_gcd);
`endif
endinterface

// File: rtl/gcd_req_scheduler_core.sv
// gcd_stein_core: a/b/k registers stepping the binary GCD under the scheduler's SHIFT/REDUCE phases
module gcd_stein_core
  import gcd_req_scheduler_pkg::*;
#(parameter int WIDTH = GCD_WIDTH) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] u_i,
  input  logic [WIDTH-1:0] v_i,
  input  state_t           state_i,
  output logic             both_even_o,
  output logic             done_o,
  output logic [WIDTH-1:0] gcd_o
);
  localparam int KW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [KW-1:0] k_q, k_d;
  assign both_even_o = ~a_q[0] & ~b_q[0];
  assign done_o = (a_q == b_q);
  assign gcd_o = a_q << k_q;
  // one Stein step per cycle: strip common twos in SHIFT, then reduce odd/even pairs
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    k_d = k_q;
    if (start_i) begin
      a_d = u_i;
      b_d = v_i;
      k_d = '0;
    end else if (state_i == SHIFT && both_even_o) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      k_d = k_q + 1'b1;
    end else if (state_i == REDUCE && !done_o) begin
      if (!a_q[0]) a_d = a_q >> 1;
      else if (!b_q[0]) b_d = b_q >> 1;
      else if (a_q > b_q) a_d = (a_q - b_q) >> 1;
      else b_d = (b_q - a_q) >> 1;
    end
  end
  // engine registers, cleared by reset so an aborted job leaves nothing behind
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      k_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      k_q <= k_d;
    end
  end
endmodule

// File: rtl/gcd_req_scheduler.sv
// gcd_req_scheduler: round-robin sharing of one Stein GCD engine; GCD_CYCLE_COUNT_EN adds rsp_cycles
module gcd_req_scheduler
  import gcd_req_scheduler_pkg::*;
#(parameter int WIDTH = GCD_WIDTH, parameter int NREQ = GCD_NREQ) (
  input logic clk,
  input logic rst_n,
  gcd_req_scheduler_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  state_t state_q;
  logic [IDW-1:0] rr_q, id_q, sel;
  logic [WIDTH-1:0] gcd_q, u_sel, v_sel, core_gcd;
  logic rsp_valid_q, found, hs, zero, both_even, core_done;
  int idx;
  // first valid requester at or after the round-robin pointer, with its operands
  always_comb begin
    found = 1'b0;
    sel = '0;
    u_sel = '0;
    v_sel = '0;
    idx = 0;
    for (int j = 0; j < NREQ; j++) begin
      idx = (int'(rr_q) + j) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        sel = IDW'(idx);
        u_sel = bus.req_u[idx*WIDTH +: WIDTH];
        v_sel = bus.req_v[idx*WIDTH +: WIDTH];
      end
    end
  end
  assign hs = (state_q == IDLE) && found;
  assign zero = (u_sel == '0) || (v_sel == '0);
  assign bus.req_ready = hs ? (NREQ'(1) << sel) : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id = id_q;
  assign bus.rsp_gcd = gcd_q;
  gcd_stein_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(hs && !zero),
    .u_i(u_sel),
    .v_i(v_sel),
    .state_i(state_q),
    .both_even_o(both_even),
    .done_o(core_done),
    .gcd_o(core_gcd)
  );
  // job sequencing: accept, run the engine, hold the response until consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      gcd_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (hs) begin
          id_q <= sel;
          rr_q <= (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;
          if (zero) begin
            gcd_q <= u_sel | v_sel;
            rsp_valid_q <= 1'b1;
            state_q <= DONE;
          end else state_q <= SHIFT;
        end
        SHIFT: if (!both_even) state_q <= REDUCE;
        REDUCE: if (core_done) begin
          gcd_q <= core_gcd;
          rsp_valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef GCD_CYCLE_COUNT_EN
  logic [WIDTH-1:0] cyc_q;
  assign bus.rsp_cycles = cyc_q;
  // saturating count of engine-busy cycles for the current job
  always_ff @(posedge clk) begin
    if (!rst_n) cyc_q <= '0;
    else if (hs) cyc_q <= '0;
    else if ((state_q == SHIFT || state_q == REDUCE) && !(&cyc_q)) cyc_q <= cyc_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_gcd_req_scheduler.sv
// tb_gcd_req_scheduler: directed checks of arbitration, zero cases, backpressure, abort and a GCD sweep
module tb_gcd_req_scheduler;
  import gcd_req_scheduler_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  gcd_req_scheduler_if #(.WIDTH(8), .NREQ(2)) bus ();
  gcd_req_scheduler #(.WIDTH(8), .NREQ(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic set_req(input int i, input logic [7:0] u, input logic [7:0] v);
    bus.req_valid[i] = 1'b1;
    bus.req_u[i*8 +: 8] = u;
    bus.req_v[i*8 +: 8] = v;
  endtask

  task automatic wait_grant(input int i);
    int t = 0;
    #1;
    while (!bus.req_ready[i] && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("grant", 32'(bus.req_ready[i]), 1);
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int id, input int g, input bit zero);
    int lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rsp_gcd", 32'(bus.rsp_gcd), g);
    chk("rsp_id", 32'(bus.rsp_id), id);
    if (zero) chk("lat_zero", lat, 1);
    else chk("lat_le_17", 32'(lat <= 17), 1);
`ifdef GCD_CYCLE_COUNT_EN
    chk("rsp_cycles", 32'(bus.rsp_cycles), lat - 1);
`endif
    @(negedge clk);
  endtask

  task automatic job(input int i, input logic [7:0] u, input logic [7:0] v);
    @(negedge clk);
    set_req(i, u, v);
    wait_grant(i);
    bus.req_valid[i] = 1'b0;
    wait_rsp(i, ref_gcd(int'(u), int'(v)), (u == 0) || (v == 0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_gcd", 32'(bus.rsp_gcd), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] cu [8] = '{8'd255, 8'd128, 8'd1, 8'd255, 8'd128, 8'd254, 8'd192, 8'd0};
    logic [7:0] cv [8] = '{8'd255, 8'd128, 8'd255, 8'd1, 8'd1, 8'd127, 8'd64, 8'd255};
    logic [7:0] u, v;
    logic [7:0] g0;
    bit any;
    bus.req_valid = '0;
    bus.req_u = '0;
    bus.req_v = '0;
    bus.rsp_ready = 1'b1;
    do_reset();
    // round robin: both requesting with pointer 0
    @(negedge clk);
    set_req(0, 8'd100, 8'd35);
    set_req(1, 8'd76, 8'd64);
    wait_grant(0);
    bus.req_valid[0] = 1'b0;
    wait_rsp(0, 5, 1'b0);
    set_req(0, 8'd100, 8'd35);
    #1;
    chk("rr_req0_blocked", 32'(bus.req_ready[0]), 0);
    wait_grant(1);
    bus.req_valid[1] = 1'b0;
    wait_rsp(1, 4, 1'b0);
    wait_grant(0);
    bus.req_valid[0] = 1'b0;
    wait_rsp(0, 5, 1'b0);
    // single requests
    job(0, 8'd100, 8'd20);
    job(0, 8'd98, 8'd8);
    job(0, 8'd127, 8'd255);
    // zero operands
    job(0, 8'd0, 8'd64);
    job(1, 8'd10, 8'd0);
    job(0, 8'd0, 8'd0);
    // backpressure with another requester waiting
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    set_req(1, 8'd48, 8'd36);
    wait_grant(1);
    bus.req_valid[1] = 1'b0;
    set_req(0, 8'd9, 8'd6);
    wait_rsp(1, 12, 1'b0);
    g0 = bus.rsp_gcd;
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_gcd", 32'(bus.rsp_gcd), 12);
      chk("bp_id", 32'(bus.rsp_id), 1);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'(bus.rsp_valid), 0);
    wait_grant(0);
    bus.req_valid[0] = 1'b0;
    wait_rsp(0, 3, 1'b0);
    // reset during REDUCE aborts the job
    @(negedge clk);
    set_req(0, 8'd100, 8'd18);
    wait_grant(0);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("in_reduce", 32'(dut.state_q), 32'(REDUCE));
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    chk("abort_rr", 32'(dut.rr_q), 0);
    rst_n = 1'b1;
    any = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      any |= bus.rsp_valid;
    end
    chk("abort_no_rsp", 32'(any), 0);
    job(0, 8'd100, 8'd18);
    // corner pairs then pseudo-random pairs against Euclid
    for (int n = 0; n < 1200; n++) begin
      u = (n < 8) ? cu[n] : 8'($urandom_range(0, 255));
      v = (n < 8) ? cv[n] : 8'($urandom_range(0, 255));
      job(n % 2, u, v);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
